core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 111 +++++++++++
 tb/tb_core_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: fetch, decode, operand request,
// memory wait, execute and writeback, with retired-instruction count.
module core_scheduler #(
  parameter int Threads_per_block = 4,
  parameter int pc_bits = 8,
  parameter int count_bits = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           start,
  input  logic [2:0]                     fetcher_state,
  input  logic [2*Threads_per_block-1:0] lsu_state,
  input  logic                           decoded_ret,
  input  logic [pc_bits-1:0]             next_pc,
  output logic [2:0]                     core_state,
  output logic [pc_bits-1:0]             current_pc,
  output logic [count_bits-1:0]          retired,
  output logic                           done
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } state_t;

  localparam logic [2:0] FETCHED = 3'b010;

  state_t                  state_q, state_d;
  logic [pc_bits-1:0]      pc_q, pc_d;
  logic [count_bits-1:0]   ret_q, ret_d;
  logic                    done_q, done_d;
  logic                    mem_busy;

  // REQUESTING (01) and WAITING (10) are the only codes whose bits differ
  always_comb begin
    mem_busy = 1'b0;
    for (int i = 0; i < Threads_per_block; i++) begin
      mem_busy = mem_busy | (lsu_state[2*i] ^ lsu_state[2*i+1]);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
          ret_d   = '0;
          done_d  = 1'b0;
        end
      end
      FETCH: begin
        if (fetcher_state == FETCHED) state_d = DECODE;
      end
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT: begin
        if (!mem_busy) state_d = EXECUTE;
      end
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        ret_d = ret_q + 1'b1;
        if (decoded_ret) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          pc_d    = next_pc;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign retired    = ret_q;
  assign done       = done_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Randomized bench for core_scheduler: expected state timeline is
// built per instruction from fetch delay, memory stall length and RET.
module tb_core_scheduler;

  localparam int T = 4;
  localparam int PCB = 8;
  localparam int CB = 4;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_FETCH = 3'b001;
  localparam logic [2:0] S_DECODE = 3'b010;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE = 3'b110;
  localparam logic [2:0] S_DONE = 3'b111;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           start;
  logic [2:0]     fetcher_state;
  logic [2*T-1:0] lsu_state;
  logic           decoded_ret;
  logic [PCB-1:0] next_pc;
  logic [2:0]     core_state;
  logic [PCB-1:0] current_pc;
  logic [CB-1:0]  retired;
  logic           done;

  int total = 0;
  int bad = 0;
  int m_pc = 0;
  int m_ret = 0;

  core_scheduler #(
    .Threads_per_block(T),
    .pc_bits(PCB),
    .count_bits(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .start(start),
    .fetcher_state(fetcher_state),
    .lsu_state(lsu_state),
    .decoded_ret(decoded_ret),
    .next_pc(next_pc),
    .core_state(core_state),
    .current_pc(current_pc),
    .retired(retired),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    fetcher_state = 3'($urandom);
    lsu_state = (2*T)'($urandom);
    decoded_ret = 1'($urandom);
    next_pc = PCB'($urandom);
  endtask

  task automatic fetch_pending();
    do fetcher_state = 3'($urandom);
    while (fetcher_state == 3'b010);
  endtask

  task automatic lsu_busy();
    int k;
    lsu_state = (2*T)'($urandom);
    k = $urandom_range(0, T-1);
    lsu_state[2*k +: 2] = ($urandom % 2) ? 2'b01 : 2'b10;
  endtask

  task automatic lsu_quiet();
    for (int i = 0; i < T; i++)
      lsu_state[2*i +: 2] = ($urandom % 2) ? 2'b11 : 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    rand_inputs();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One kernel from IDLE through DONE and back to IDLE.
  task automatic run_kernel(input int n, input bit det, input int hold);
    int f, w;
    logic [PCB-1:0] npc;
    bit last;
    rand_inputs();
    start = 1'b1;
    tick();
    total++;
    if (core_state !== S_FETCH || current_pc !== 0 ||
        retired !== 0 || done !== 1'b0) begin
      bad++;
      $display("FAIL kick: st=%0d pc=%0d ret=%0d done=%0b want 1/0/0/0",
               core_state, current_pc, retired, done);
    end
    m_pc = 0;
    m_ret = 0;
    for (int i = 0; i < n; i++) begin
      f = det ? 0 : $urandom_range(0, 3);
      w = det ? 0 : $urandom_range(0, 4);
      last = (i == n-1);
      for (int j = 0; j <= f; j++) begin
        rand_inputs();
        start = 1'($urandom);
        if (j == f) fetcher_state = 3'b010;
        else fetch_pending();
        tick();
        total++;
        if (core_state !== ((j == f) ? S_DECODE : S_FETCH)) begin
          bad++;
          $display("FAIL fetch i=%0d j=%0d: st=%0d want %0d", i, j,
                   core_state, (j == f) ? S_DECODE : S_FETCH);
        end
      end
      rand_inputs();
      start = 1'($urandom);
      tick();
      total++;
      if (core_state !== S_REQUEST) begin
        bad++;
        $display("FAIL decode i=%0d: st=%0d want %0d", i, core_state,
                 S_REQUEST);
      end
      rand_inputs();
      start = 1'($urandom);
      tick();
      total++;
      if (core_state !== S_WAIT) begin
        bad++;
        $display("FAIL request i=%0d: st=%0d want %0d", i, core_state,
                 S_WAIT);
      end
      for (int j = 0; j <= w; j++) begin
        rand_inputs();
        start = 1'($urandom);
        if (j == w) lsu_quiet();
        else lsu_busy();
        if (det) lsu_state = '0;
        tick();
        total++;
        if (core_state !== ((j == w) ? S_EXECUTE : S_WAIT)) begin
          bad++;
          $display("FAIL wait i=%0d j=%0d: st=%0d want %0d", i, j,
                   core_state, (j == w) ? S_EXECUTE : S_WAIT);
        end
      end
      rand_inputs();
      start = 1'($urandom);
      tick();
      total++;
      if (core_state !== S_UPDATE || current_pc !== PCB'(m_pc) ||
          retired !== CB'(m_ret)) begin
        bad++;
        $display("FAIL execute i=%0d: st=%0d pc=%0d ret=%0d want %0d/%0d/%0d",
                 i, core_state, current_pc, retired, S_UPDATE, m_pc, m_ret);
      end
      rand_inputs();
      start = 1'($urandom);
      npc = det ? PCB'(m_pc + 1) : PCB'($urandom);
      next_pc = npc;
      decoded_ret = last;
      tick();
      m_ret = (m_ret + 1) % (1 << CB);
      if (!last) m_pc = npc;
      total++;
      if (core_state !== (last ? S_DONE : S_FETCH) ||
          current_pc !== PCB'(m_pc) || retired !== CB'(m_ret) ||
          done !== last) begin
        bad++;
        $display("FAIL update i=%0d: st=%0d pc=%0d ret=%0d done=%0b want %0d/%0d/%0d/%0b",
                 i, core_state, current_pc, retired, done,
                 last ? S_DONE : S_FETCH, m_pc, m_ret, last);
      end
    end
    for (int h = 0; h < hold; h++) begin
      rand_inputs();
      start = 1'b1;
      tick();
      total++;
      if (core_state !== S_DONE || done !== 1'b1) begin
        bad++;
        $display("FAIL done_hold h=%0d: st=%0d done=%0b want %0d/1", h,
                 core_state, done, S_DONE);
      end
    end
    rand_inputs();
    start = 1'b0;
    tick();
    total++;
    if (core_state !== S_IDLE || done !== 1'b0 ||
        retired !== CB'(m_ret) || current_pc !== PCB'(m_pc)) begin
      bad++;
      $display("FAIL done_drop: st=%0d done=%0b ret=%0d pc=%0d want 0/0/%0d/%0d",
               core_state, done, retired, current_pc, m_ret, m_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    start = 1'b1;
    rand_inputs();
    tick();
    tick();
    total++;
    if (core_state !== S_IDLE || current_pc !== 0 || retired !== 0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: st=%0d pc=%0d ret=%0d done=%0b want all 0",
               core_state, current_pc, retired, done);
    end
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
    end
    total++;
    if (core_state !== S_IDLE) begin
      bad++;
      $display("FAIL idle_no_start: st=%0d want 0", core_state);
    end
    enable = 1'b0;
    start = 1'b1;
    tick();
    total++;
    if (core_state !== S_IDLE) begin
      bad++;
      $display("FAIL idle_disabled: st=%0d want 0", core_state);
    end
    enable = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_straight_line();
    run_kernel(4, 1'b1, 0);
    total++;
    if (retired !== 4'd4 || current_pc !== 8'd3) begin
      bad++;
      $display("FAIL straight_line: ret=%0d pc=%0d want 4/3", retired,
               current_pc);
    end
  endtask

  task automatic test_random_kernels();
    for (int k = 0; k < 6; k++)
      run_kernel($urandom_range(1, 6), 1'b0, $urandom_range(0, 3));
  endtask

  task automatic test_counter_wrap();
    run_kernel(18, 1'b0, 1);
    total++;
    if (retired !== 4'd2) begin
      bad++;
      $display("FAIL counter_wrap: ret=%0d want 2", retired);
    end
  endtask

  task automatic test_memory_stall();
    logic [1:0] t2;
    rand_inputs();
    start = 1'b1;
    tick();
    fetcher_state = 3'b010;
    tick();
    tick();
    tick();
    total++;
    if (core_state !== S_WAIT) begin
      bad++;
      $display("FAIL stall_enter: st=%0d want %0d", core_state, S_WAIT);
    end
    for (int c = 0; c < 6; c++) begin
      rand_inputs();
      lsu_quiet();
      t2 = (c < 3) ? 2'b01 : (c < 5) ? 2'b10 : 2'b11;
      lsu_state[5:4] = t2;
      tick();
      total++;
      if (core_state !== ((c < 5) ? S_WAIT : S_EXECUTE)) begin
        bad++;
        $display("FAIL stall c=%0d: st=%0d want %0d", c, core_state,
                 (c < 5) ? S_WAIT : S_EXECUTE);
      end
    end
    rand_inputs();
    tick();
    decoded_ret = 1'b1;
    tick();
    total++;
    if (core_state !== S_DONE || retired !== 4'd1 || done !== 1'b1) begin
      bad++;
      $display("FAIL stall_ret: st=%0d ret=%0d done=%0b want 7/1/1",
               core_state, retired, done);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_done_handshake();
    run_kernel(2, 1'b0, 10);
    rand_inputs();
    start = 1'b1;
    tick();
    total++;
    if (core_state !== S_FETCH || retired !== 0 || current_pc !== 0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL restart: st=%0d ret=%0d pc=%0d done=%0b want 1/0/0/0",
               core_state, retired, current_pc, done);
    end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    rand_inputs();
    start = 1'b1;
    tick();
    fetcher_state = 3'b010;
    tick();
    for (int i = 0; i < 5; i++) begin
      enable = 1'b0;
      rand_inputs();
      start = 1'($urandom);
      tick();
      total++;
      if (core_state !== S_DECODE || current_pc !== 0 || retired !== 0 ||
          done !== 1'b0) begin
        bad++;
        $display("FAIL freeze i=%0d: st=%0d pc=%0d ret=%0d done=%0b want 2/0/0/0",
                 i, core_state, current_pc, retired, done);
      end
    end
    enable = 1'b1;
    rand_inputs();
    tick();
    total++;
    if (core_state !== S_REQUEST) begin
      bad++;
      $display("FAIL unfreeze: st=%0d want %0d", core_state, S_REQUEST);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    run_kernel(1, 1'b0, 0);
    rand_inputs();
    start = 1'b1;
    tick();
    fetcher_state = 3'b010;
    tick();
    tick();
    tick();
    lsu_busy();
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (core_state !== S_IDLE || current_pc !== 0 || retired !== 0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wait: st=%0d pc=%0d ret=%0d done=%0b want all 0",
               core_state, current_pc, retired, done);
    end
    tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    total++;
    if (core_state !== S_IDLE) begin
      bad++;
      $display("FAIL post_reset_idle: st=%0d want 0", core_state);
    end
    start = 1'b1;
    tick();
    total++;
    if (core_state !== S_FETCH) begin
      bad++;
      $display("FAIL post_reset_start: st=%0d want 1", core_state);
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_random_kernels();
    test_counter_wrap();
    test_memory_stall();
    test_done_handshake();
    test_enable_freeze();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
